pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the P7 five-stage MIPS core (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_reg_pkg.sv | 43 ++++
 rtl/pipe_skid_buf.sv | 68 ++++++
 rtl/pipe_stage_reg.sv | 194 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared constants and types for the P7 inter-stage pipeline registers.
//   INITIAL_ADDRESS : PC presented after reset
//   TRAPPED_ADDRESS : PC presented after an interrupt/exception flush
//   EXC_W           : ExcCode field width
//   ctrl_e          : per-edge control decision (trap > flush > run)
//   skid_state_e    : occupancy of the one-entry skid store
//   `PIPE_PAYLOAD   : fixed field order (instr|pc|exc|bd|side) used wherever
//                     a stage packs its payload into one vector

package pipe_stage_reg_pkg;

  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] TRAPPED_ADDRESS = 32'h0000_4180;
  localparam int unsigned EXC_W           = 5;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_FLUSH,
    CTRL_TRAP
  } ctrl_e;

  typedef enum logic {
    SKID_EMPTY,
    SKID_FULL
  } skid_state_e;

  // Reset is handled in the register process; this resolves the remaining
  // priority between interrupt flush and plain flush.
  function automatic ctrl_e ctrl_decode(input logic int_req, input logic flush);
    if (int_req) begin
      return CTRL_TRAP;
    end else if (flush) begin
      return CTRL_FLUSH;
    end
    return CTRL_RUN;
  endfunction

endpackage

`ifndef PIPE_PAYLOAD
`define PIPE_PAYLOAD(instr, pc, exc, bd, side) {instr, pc, exc, bd, side}
`endif

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
//   One-entry payload store with a full flag and a synchronous clear.
//   clk   in  1  clock, rising edge
//   reset in  1  synchronous active-high reset (empties the store)
//   clr   in  1  empties the store (flush / interrupt)
//   push  in  1  write din into the store
//   pop   in  1  release the stored entry
//   din   in  W  payload to store
//   dout  out W  stored payload
//   full  out 1  store holds an entry

module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);
  import pipe_stage_reg_pkg::*;

  skid_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (clr) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d = SKID_FULL;
            data_d  = din;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            state_d = push ? SKID_FULL : SKID_EMPTY;
            if (push) begin
              data_d = din;
            end
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  assign dout = data_q;
  assign full = (state_q == SKID_FULL);

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register (F/D, D/E, E/M, M/W) of the P7 MIPS core.
//   Valid/ready handshake; per-edge priority reset > int_req > flush > handshake.
//   Optional feature macro: PIPE_SKID_EN (adds a one-entry skid buffer so that
//   in_ready is registered; undefined = single register, combinational in_ready).
// Ports
//   clk, reset            clock (rising) and synchronous active-high reset
//   int_req               flush toward the handler; out_pc <- TRAP_PC
//   flush                 bubble insert; out_pc and out_bd kept
//   in_valid / in_ready   upstream handshake
//   in_instr/pc/exc/bd/side  incoming payload
//   out_valid / out_ready downstream handshake
//   out_instr/pc/exc/bd/side registered payload
//   stall_cnt             saturating count of cycles with out_valid & ~out_ready

module pipe_stage_reg #(
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     EXC_W    = pipe_stage_reg_pkg::EXC_W,
  parameter int unsigned     SIDE_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(pipe_stage_reg_pkg::INITIAL_ADDRESS),
  parameter logic [PC_W-1:0] TRAP_PC  = PC_W'(pipe_stage_reg_pkg::TRAPPED_ADDRESS),
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               int_req,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [SIDE_W-1:0]  out_side,
  output logic [CNT_W-1:0]   stall_cnt
);
  import pipe_stage_reg_pkg::*;

  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q,    out_pc_d;
  logic [EXC_W-1:0]   out_exc_q,   out_exc_d;
  logic               out_bd_q,    out_bd_d;
  logic [SIDE_W-1:0]  out_side_q,  out_side_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  ctrl_e ctrl;
  logic  stalled;
  logic  load;
  logic  in_ready_int;
  logic  in_xfer;

  // Beat offered to the output register when it loads.
  logic               beat_valid;
  logic [INSTR_W-1:0] beat_instr;
  logic [PC_W-1:0]    beat_pc;
  logic [EXC_W-1:0]   beat_exc;
  logic               beat_bd;
  logic [SIDE_W-1:0]  beat_side;

  assign ctrl    = ctrl_decode(int_req, flush);
  assign stalled = out_valid_q & ~out_ready;
  assign load    = ~stalled;

`ifdef PIPE_SKID_EN
  localparam int unsigned PAY_W = INSTR_W + PC_W + EXC_W + 1 + SIDE_W;

  logic             skid_full;
  logic             skid_push;
  logic             skid_pop;
  logic             skid_clr;
  logic [PAY_W-1:0] skid_dout;

  // in_ready depends only on the skid flop, so it never waits on out_ready.
  assign in_ready_int = ~skid_full;
  assign in_xfer      = in_valid & in_ready_int;
  assign skid_clr     = (ctrl != CTRL_RUN);
  assign skid_push    = in_xfer & stalled;
  assign skid_pop     = skid_full & load;

  // A full skid entry is older than anything on the input, so it goes first.
  assign beat_valid = skid_full | in_xfer;
  assign {beat_instr, beat_pc, beat_exc, beat_bd, beat_side} =
      skid_full ? skid_dout : `PIPE_PAYLOAD(in_instr, in_pc, in_exc, in_bd, in_side);

  pipe_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (skid_clr),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (`PIPE_PAYLOAD(in_instr, in_pc, in_exc, in_bd, in_side)),
    .dout  (skid_dout),
    .full  (skid_full)
  );
`else
  assign in_ready_int = load;
  assign in_xfer      = in_valid & in_ready_int;
  assign beat_valid   = in_xfer;
  assign beat_instr   = in_instr;
  assign beat_pc      = in_pc;
  assign beat_exc     = in_exc;
  assign beat_bd      = in_bd;
  assign beat_side    = in_side;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= RESET_PC;
      out_exc_q   <= '0;
      out_bd_q    <= 1'b0;
      out_side_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_exc_q   <= out_exc_d;
      out_bd_q    <= out_bd_d;
      out_side_q  <= out_side_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_exc_d   = out_exc_q;
    out_bd_d    = out_bd_q;
    out_side_d  = out_side_q;
    stall_cnt_d = stall_cnt_q;

    // Counted even on flush/interrupt cycles; only reset clears it.
    if (stalled && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    unique case (ctrl)
      CTRL_TRAP: begin
        out_valid_d = 1'b0;
        out_instr_d = '0;
        out_pc_d    = TRAP_PC;
        out_exc_d   = '0;
        out_bd_d    = 1'b0;
        out_side_d  = '0;
      end
      CTRL_FLUSH: begin
        // PC and BD stay so EPC/macro-PC remain correct for the killed slot.
        out_valid_d = 1'b0;
        out_instr_d = '0;
        out_exc_d   = '0;
        out_side_d  = '0;
      end
      default: begin
        if (load) begin
          if (beat_valid) begin
            out_valid_d = 1'b1;
            out_instr_d = beat_instr;
            out_pc_d    = beat_pc;
            out_exc_d   = beat_exc;
            out_bd_d    = beat_bd;
            out_side_d  = beat_side;
          end else begin
            out_valid_d = 1'b0;
            out_instr_d = '0;
          end
        end
      end
    endcase
  end

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_exc   = out_exc_q;
  assign out_bd    = out_bd_q;
  assign out_side  = out_side_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Randomised + directed bench for pipe_stage_reg. A second instance with
//   CNT_W=2 shares all inputs to exercise stall counter saturation.
//   Honours PIPE_SKID_EN when the bench is built with the same define.

module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic [7:0]  side;
  } pay_t;

`ifdef PIPE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk;
  logic        reset, int_req, flush, in_valid, out_ready;
  pay_t        in_p;

  logic        in_ready_a, out_valid_a, out_bd_a;
  logic [31:0] out_instr_a, out_pc_a;
  logic [4:0]  out_exc_a;
  logic [7:0]  out_side_a;
  logic [15:0] stall_cnt_a;

  logic        in_ready_b, out_valid_b, out_bd_b;
  logic [31:0] out_instr_b, out_pc_b;
  logic [4:0]  out_exc_b;
  logic [7:0]  out_side_b;
  logic [1:0]  stall_cnt_b;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .int_req(int_req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_p.instr), .in_pc(in_p.pc), .in_exc(in_p.exc),
    .in_bd(in_p.bd), .in_side(in_p.side),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_instr(out_instr_a), .out_pc(out_pc_a), .out_exc(out_exc_a),
    .out_bd(out_bd_a), .out_side(out_side_a), .stall_cnt(stall_cnt_a)
  );

  pipe_stage_reg #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .int_req(int_req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_p.instr), .in_pc(in_p.pc), .in_exc(in_p.exc),
    .in_bd(in_p.bd), .in_side(in_p.side),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_pc(out_pc_b), .out_exc(out_exc_b),
    .out_bd(out_bd_b), .out_side(out_side_b), .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of beats owned by the stage (head shown
  // on the outputs), the last displayed fields, and a plain stall total.
  pay_t        mq[$];
  pay_t        disp;
  int unsigned stall_total;
  bit          model_init;

  function automatic bit model_in_ready(input logic orr);
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || orr;
  endfunction

  task automatic model_edge(input logic rst, input logic ir, input logic fl,
                            input logic iv, input logic orr, input pay_t p);
    bit stalled;
    bit acc;
    stalled = (mq.size() > 0) && !orr;
    acc     = iv && model_in_ready(orr);
    if (rst) begin
      mq.delete();
      disp        = '{instr: 32'h0, pc: 32'h3000, exc: 5'd0, bd: 1'b0, side: 8'd0};
      stall_total = 0;
      model_init  = 1'b1;
    end else begin
      if (stalled) stall_total++;
      if (ir) begin
        mq.delete();
        disp = '{instr: 32'h0, pc: 32'h4180, exc: 5'd0, bd: 1'b0, side: 8'd0};
      end else if (fl) begin
        mq.delete();
        disp.instr = '0;
        disp.exc   = '0;
        disp.side  = '0;
      end else begin
        if (!stalled && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(p);
        if (mq.size() > 0) disp = mq[0];
        else disp.instr = '0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic ir, input logic fl,
                      input logic iv, input logic orr, input pay_t p);
    int unsigned sat16;
    int unsigned sat2;
    reset = rst; int_req = ir; flush = fl; in_valid = iv; out_ready = orr; in_p = p;
    #1;
    if (model_init) begin
      check_eq("in_ready", 64'(in_ready_a), 64'(model_in_ready(orr)));
    end
    @(posedge clk);
    model_edge(rst, ir, fl, iv, orr, p);
    #1;
    sat16 = (stall_total > 65535) ? 65535 : stall_total;
    sat2  = (stall_total > 3) ? 3 : stall_total;
    check_eq("out_valid", 64'(out_valid_a), 64'(mq.size() > 0));
    check_eq("out_instr", 64'(out_instr_a), 64'(disp.instr));
    check_eq("out_pc",    64'(out_pc_a),    64'(disp.pc));
    check_eq("out_exc",   64'(out_exc_a),   64'(disp.exc));
    check_eq("out_bd",    64'(out_bd_a),    64'(disp.bd));
    check_eq("out_side",  64'(out_side_a),  64'(disp.side));
    check_eq("stall_cnt", 64'(stall_cnt_a), 64'(sat16));
    check_eq("stall_cnt_sat", 64'(stall_cnt_b), 64'(sat2));
  endtask

  function automatic pay_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic bd, input logic [7:0] side);
    pay_t r;
    r.instr = instr; r.pc = pc; r.exc = 5'd0; r.bd = bd; r.side = side;
    return r;
  endfunction

  function automatic pay_t rnd_pay();
    pay_t r;
    r.instr = $urandom;
    r.pc    = $urandom;
    r.exc   = 5'($urandom_range(0, 31));
    r.bd    = 1'($urandom_range(0, 1));
    r.side  = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    pay_t z;
    n_vec = 0; n_bad = 0; model_init = 1'b0; stall_total = 0;
    z = '0;

    // Reset
    step(1, 0, 0, 0, 1, z);
    check_eq("rst_pc", 64'(out_pc_a), 64'h3000);
    check_eq("rst_valid", 64'(out_valid_a), 64'h0);
    check_eq("rst_stall_cnt", 64'(stall_cnt_a), 64'h0);
    check_eq("rst_in_ready", 64'(in_ready_a), 64'h1);

    // Stream five beats back to back
    for (int unsigned i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1, 1, mk(32'h2408_0000 + i, 32'h3000 + 4 * i, 1'b0, 8'(i)));
      check_eq("stream_instr", 64'(out_instr_a), 64'(32'h2408_0000 + i));
      check_eq("stream_valid", 64'(out_valid_a), 64'h1);
    end
    step(0, 0, 0, 0, 1, z);

    // Stall three cycles with a second beat pending
    step(0, 0, 0, 1, 1, mk(32'h1111_0001, 32'h3100, 1'b0, 8'h11));
    for (int unsigned i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, mk(32'h1111_0002, 32'h3104, 1'b0, 8'h12));
      check_eq("stall_hold_instr", 64'(out_instr_a), 64'h1111_0001);
    end
    check_eq("stall_cnt3", 64'(stall_cnt_a), 64'd3);
    check_eq("stall_sat3", 64'(stall_cnt_b), 64'd3);
    step(0, 0, 0, 0, 1, z);
    step(0, 0, 0, 0, 1, z);

    // int_req during a stall with a beat offered
    step(0, 0, 0, 1, 1, mk(32'h2222_0001, 32'h3200, 1'b1, 8'h21));
    step(0, 0, 0, 1, 0, mk(32'h2222_0002, 32'h3204, 1'b0, 8'h22));
    step(0, 1, 0, 1, 0, mk(32'h2222_0003, 32'h3208, 1'b0, 8'h23));
    check_eq("irq_valid", 64'(out_valid_a), 64'h0);
    check_eq("irq_pc", 64'(out_pc_a), 64'h4180);
    check_eq("irq_bd", 64'(out_bd_a), 64'h0);
    check_eq("irq_sat", 64'(stall_cnt_b), 64'd3);
    step(0, 0, 0, 0, 1, z);
    check_eq("irq_dropped", 64'(out_valid_a), 64'h0);

    // Flush keeps PC and BD
    step(0, 0, 0, 1, 0, mk(32'h3333_0001, 32'h3010, 1'b1, 8'h31));
    step(0, 0, 1, 1, 1, mk(32'h3333_0002, 32'h3014, 1'b0, 8'h32));
    check_eq("flush_valid", 64'(out_valid_a), 64'h0);
    check_eq("flush_instr", 64'(out_instr_a), 64'h0);
    check_eq("flush_pc", 64'(out_pc_a), 64'h3010);
    check_eq("flush_bd", 64'(out_bd_a), 64'h1);

    // int_req and flush together: trap wins
    step(0, 0, 0, 1, 1, mk(32'h4444_0001, 32'h3400, 1'b1, 8'h41));
    step(0, 1, 1, 1, 1, mk(32'h4444_0002, 32'h3404, 1'b0, 8'h42));
    check_eq("both_pc", 64'(out_pc_a), 64'h4180);
    check_eq("both_valid", 64'(out_valid_a), 64'h0);

    // Randomised traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 99) < 2),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           rnd_pay());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
